complex_alu_feeder: RTL and testbench

//  Upstream issue stage for the packed-complex ALU. Collects a 16-bit beat stream
//  (op1 re, op1 im, op2 re, op2 im, opcode) over a valid/ready handshake.

---
 rtl/complex_alu_feeder.sv | 105 ++++++++++
 tb/tb_complex_alu_feeder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/complex_alu_feeder.sv
// complex_alu_feeder: gathers five 16-bit beats into one packed-complex
// command (two operands plus opcode) and issues it to the ALU stage.
module complex_alu_feeder #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic [2*DATA_W-1:0] operand1,
    output logic [2*DATA_W-1:0] operand2,
    output logic [3:0]          opcode,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic                err_illegal,
    output logic [CNT_W-1:0]    issue_count
);

    typedef enum logic [2:0] {
        S_OP1_RE = 3'd0,
        S_OP1_IM = 3'd1,
        S_OP2_RE = 3'd2,
        S_OP2_IM = 3'd3,
        S_OPC    = 3'd4,
        S_ISSUE  = 3'd5
    } state_t;

    state_t              state_q;
    logic [2*DATA_W-1:0] op1_q;
    logic [2*DATA_W-1:0] op2_q;
    logic [3:0]          opc_q;
    logic                valid_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                beat;
    logic                legal;

    // Every load state takes beats; ready is held low while in reset.
    assign in_ready = rst_n & (state_q != S_ISSUE);
    assign beat     = in_valid & in_ready;
    assign legal    = (in_data[3:0] <= 4'd2);

    // Beat assembly, opcode check and issue handshake in one registered FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OP1_RE;
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= S_OP1_RE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_OP1_RE: if (beat) begin
                    op1_q[2*DATA_W-1:DATA_W] <= in_data;
                    state_q <= S_OP1_IM;
                end
                S_OP1_IM: if (beat) begin
                    op1_q[DATA_W-1:0] <= in_data;
                    state_q <= S_OP2_RE;
                end
                S_OP2_RE: if (beat) begin
                    op2_q[2*DATA_W-1:DATA_W] <= in_data;
                    state_q <= S_OP2_IM;
                end
                S_OP2_IM: if (beat) begin
                    op2_q[DATA_W-1:0] <= in_data;
                    state_q <= S_OPC;
                end
                S_OPC: if (beat) begin
                    if (legal) begin
                        opc_q   <= in_data[3:0];
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_OP1_RE;
                    end
                end
                S_ISSUE: if (issue_ready) begin
                    cnt_q   <= cnt_q + 1'b1;
                    valid_q <= 1'b0;
                    state_q <= S_OP1_RE;
                end
                default: state_q <= S_OP1_RE;
            endcase
        end
    end

    assign operand1    = op1_q;
    assign operand2    = op2_q;
    assign opcode      = opc_q;
    assign issue_valid = valid_q;
    assign err_illegal = err_q;
    assign issue_count = cnt_q;

endmodule

// File: tb/tb_complex_alu_feeder.sv
// tb_complex_alu_feeder: directed and randomized commands checked
// against a command-level model of the feeder.
module tb_complex_alu_feeder;

    localparam int DW = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2*DW-1:0] operand1;
    logic [2*DW-1:0] operand2;
    logic [3:0]    opcode;
    logic          issue_valid;
    logic          issue_ready;
    logic          err_illegal;
    logic [CW-1:0] issue_count;

    complex_alu_feeder #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .operand1    (operand1),
        .operand2    (operand2),
        .opcode      (opcode),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .err_illegal (err_illegal),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [3:0]  m_opc;
    logic        m_err;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".op1"}, operand1, m_op1);
        chk({tag, ".op2"}, operand2, m_op2);
        chk({tag, ".opc"}, {28'd0, opcode}, {28'd0, m_opc});
        chk({tag, ".err"}, {31'd0, err_illegal}, {31'd0, m_err});
        chk({tag, ".cnt"}, {30'd0, issue_count}, m_cnt % 4);
    endtask

    task automatic send_beat(input logic [15:0] d, input int maxgap);
        int g;
        g = $urandom_range(0, maxgap);
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        chk("beat.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic run_cmd(input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3,
                           input logic [15:0] b4, input int maxgap,
                           input int hold, input bit flush_issue);
        send_beat(b0, maxgap);
        send_beat(b1, maxgap);
        send_beat(b2, maxgap);
        send_beat(b3, maxgap);
        send_beat(b4, maxgap);
        m_op1 = {b0, b1};
        m_op2 = {b2, b3};
        @(negedge clk);
        in_valid    = 1'b0;
        issue_ready = 1'b0;
        if (b4[3:0] > 4'd2) begin
            m_err = 1'b1;
            chk("ill.valid", {31'd0, issue_valid}, 32'd0);
            chk("ill.in_ready", {31'd0, in_ready}, 32'd1);
            chk_regs("ill");
        end else begin
            m_opc = b4[3:0];
            chk("iss.valid", {31'd0, issue_valid}, 32'd1);
            chk("iss.in_ready", {31'd0, in_ready}, 32'd0);
            chk_regs("iss");
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom);
                in_data  = 16'($urandom);
                @(posedge clk);
                @(negedge clk);
                chk("hold.valid", {31'd0, issue_valid}, 32'd1);
                chk("hold.in_ready", {31'd0, in_ready}, 32'd0);
                chk_regs("hold");
            end
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            if (flush_issue) flush = 1'b1;
            else issue_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            flush       = 1'b0;
            issue_ready = 1'b0;
            in_valid    = 1'b0;
            if (flush_issue) m_err = 1'b0;
            else m_cnt++;
            chk("done.valid", {31'd0, issue_valid}, 32'd0);
            chk("done.in_ready", {31'd0, in_ready}, 32'd1);
            chk_regs("done");
        end
    endtask

    task automatic partial_flush(input logic [15:0] b0, input logic [15:0] b1,
                                 input logic [15:0] b2);
        send_beat(b0, 1);
        send_beat(b1, 1);
        send_beat(b2, 1);
        m_op1 = {b0, b1};
        m_op2[31:16] = b2;
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        m_err    = 1'b0;
        chk("flush.valid", {31'd0, issue_valid}, 32'd0);
        chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
        chk_regs("flush");
    endtask

    initial begin
        logic [15:0] r4;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        issue_ready = 1'b0;
        m_op1 = '0; m_op2 = '0; m_opc = '0; m_err = 1'b0; m_cnt = 0;
        #1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst.valid", {31'd0, issue_valid}, 32'd0);
        chk_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready", {31'd0, in_ready}, 32'd1);

        run_cmd(16'h0003, 16'h0004, 16'h0001, 16'h0002, 16'h0002, 0, 0, 0);
        run_cmd(16'h0003, 16'h0004, 16'h0001, 16'h0002, 16'h0002, 0, 5, 0);
        run_cmd(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0007, 0, 0, 0);
        run_cmd(16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0000, 0, 1, 0);
        run_cmd(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h000F, 0, 0, 0);
        partial_flush(16'h9999, 16'h8888, 16'h7777);
        run_cmd(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0001, 0, 0, 0);
        run_cmd(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'hFFF1, 3, 2, 0);
        run_cmd(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, 16'h0002, 0, 2, 1);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 5) == 0)
                partial_flush(16'($urandom), 16'($urandom), 16'($urandom));
            r4 = 16'($urandom);
            if ($urandom_range(0, 9) < 7)
                r4[3:0] = 4'($urandom_range(0, 2));
            run_cmd(16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), r4, 2, $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0));
        end

        send_beat(16'h0101, 0);
        send_beat(16'h0202, 0);
        send_beat(16'h0303, 0);
        send_beat(16'h0404, 0);
        send_beat(16'h0000, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst.valid", {31'd0, issue_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        m_op1 = '0; m_op2 = '0; m_opc = '0; m_err = 1'b0; m_cnt = 0;
        chk("mid_rst.valid", {31'd0, issue_valid}, 32'd0);
        chk("mid_rst.in_ready", {31'd0, in_ready}, 32'd0);
        chk_regs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
        run_cmd(16'h0003, 16'h0004, 16'h0001, 16'h0002, 16'h0000, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
